// File: rtl/host_stream_packer.sv
// Round-robin merge of N_CHAN AXI4-Stream channels onto one host stream,
// packing partially filled beats into full-width words.
//
// state  | meaning
// IDLE   | scan for a requesting channel starting at rr, register grant
// LOCKED | stream beats from the granted channel into the packer
// FLUSH  | emit the remainder left by a tlast beat that overflowed a word
module host_stream_packer #(
    parameter int N_CHAN     = 4,
    parameter int DATA_BYTES = 64,
    parameter int TID_W      = 6
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_CHAN*DATA_BYTES*8-1:0] s_tdata,
    input  logic [N_CHAN*DATA_BYTES-1:0]   s_tkeep,
    input  logic [N_CHAN-1:0]              s_tlast,
    input  logic [N_CHAN-1:0]              s_tvalid,
    output logic [N_CHAN-1:0]              s_tready,
    output logic [DATA_BYTES*8-1:0]        m_tdata,
    output logic [DATA_BYTES-1:0]          m_tkeep,
    output logic [TID_W-1:0]               m_tid,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready
);
    localparam int DW = DATA_BYTES * 8;
    localparam int KW = $clog2(DATA_BYTES + 1);
    localparam int TW = KW + 1;
    localparam int GW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [TW-1:0] DB_T    = TW'(DATA_BYTES);
    localparam logic [GW-1:0] LAST_CH = GW'(N_CHAN - 1);

    typedef enum logic [1:0] {IDLE, LOCKED, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_q, rr_d, rr_after;
    logic [DW-1:0]         acc_q, acc_d;
    logic [KW-1:0]         fill_q, fill_d;

    logic [DW-1:0]         sel_data;
    logic [DATA_BYTES-1:0] sel_keep;
    logic                  sel_last;
    logic                  sel_valid;
    logic [DW-1:0]         new_bytes;
    logic [KW-1:0]         beat_k;
    logic [TW-1:0]         total;
    logic [2*DW-1:0]       merged;

    logic                  scan_found;
    logic [GW-1:0]         scan_idx;
    logic                  out_free;
    logic                  accept;

    logic                  load;
    logic [DW-1:0]         ld_data;
    logic [DATA_BYTES-1:0] ld_keep;
    logic                  ld_last;

    function automatic logic [DATA_BYTES-1:0] prefix_keep(input logic [TW-1:0] n);
        logic [DATA_BYTES-1:0] m;
        for (int i = 0; i < DATA_BYTES; i++) begin
            m[i] = (TW'(i) < n);
        end
        return m;
    endfunction

    always_comb begin
        sel_data  = s_tdata[int'(grant_q)*DW +: DW];
        sel_keep  = s_tkeep[int'(grant_q)*DATA_BYTES +: DATA_BYTES];
        sel_last  = s_tlast[grant_q];
        sel_valid = s_tvalid[grant_q];
    end

    // Lanes beyond the keep prefix are zeroed so the accumulator never holds
    // stale bytes above its fill level.
    always_comb begin
        beat_k    = '0;
        new_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            beat_k = beat_k + KW'(sel_keep[i]);
            new_bytes[i*8 +: 8] = sel_keep[i] ? sel_data[i*8 +: 8] : 8'h00;
        end
        total  = {1'b0, fill_q} + {1'b0, beat_k};
        merged = {{DW{1'b0}}, acc_q} | ({{DW{1'b0}}, new_bytes} << {fill_q, 3'b000});
    end

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (!scan_found && s_tvalid[(int'(rr_q) + i) % N_CHAN]) begin
                scan_found = 1'b1;
                scan_idx   = GW'((int'(rr_q) + i) % N_CHAN);
            end
        end
    end

    assign out_free = !m_tvalid || m_tready;
    assign accept   = (state_q == LOCKED) && sel_valid && out_free;
    assign rr_after = (grant_q == LAST_CH) ? '0 : grant_q + GW'(1);

    always_comb begin
        s_tready = '0;
        if (state_q == LOCKED) begin
            s_tready[grant_q] = out_free;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        load    = 1'b0;
        ld_data = '0;
        ld_keep = '0;
        ld_last = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    grant_d = scan_idx;
                    state_d = LOCKED;
                end
            end

            LOCKED: begin
                if (accept) begin
                    if (sel_last && (total > DB_T)) begin
                        load    = 1'b1;
                        ld_data = merged[DW-1:0];
                        ld_keep = '1;
                        acc_d   = merged[2*DW-1:DW];
                        fill_d  = KW'(total - DB_T);
                        state_d = FLUSH;
                    end else if (sel_last) begin
                        // Covers the empty packet too: total = 0 gives keep 0.
                        load    = 1'b1;
                        ld_data = merged[DW-1:0];
                        ld_keep = prefix_keep(total);
                        ld_last = 1'b1;
                        acc_d   = '0;
                        fill_d  = '0;
                        rr_d    = rr_after;
                        state_d = IDLE;
                    end else if (total >= DB_T) begin
                        load    = 1'b1;
                        ld_data = merged[DW-1:0];
                        ld_keep = '1;
                        acc_d   = merged[2*DW-1:DW];
                        fill_d  = KW'(total - DB_T);
                    end else begin
                        acc_d   = merged[DW-1:0];
                        fill_d  = KW'(total);
                    end
                end
            end

            FLUSH: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = acc_q;
                    ld_keep = prefix_keep({1'b0, fill_q});
                    ld_last = 1'b1;
                    acc_d   = '0;
                    fill_d  = '0;
                    rr_d    = rr_after;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            acc_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
        end
    end

    // Single output register stage; contents are held while stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= ld_data;
            m_tkeep  <= ld_keep;
            m_tlast  <= ld_last;
            m_tid    <= TID_W'(grant_q);
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule
